vend_ctrl: RTL and testbench
============================

Name: vend_ctrl

Overview:
- Parametrised successor to the fixed-price soda vending FSM.
- Accumulates coin credit against a programmable price in 5-cent units. Pulses soda_o when credit reaches the price.
- Returns change, or a full refund on cancel, as a stream of individual coins over a valid/ready handshake to the coin-hopper driver.
- Sits between the coin-acceptor front end and the dispenser/hopper actuators.

Parameters:
- PRICE_U, 4, product price in 5-cent units (4 = 20 cents); legal range 1..MAX_CREDIT_U.
- MAX_CREDIT_U, 15, maximum credit held, in 5-cent units; must be >= PRICE_U+4.
- CREDIT_W, $clog2(MAX_CREDIT_U+1), credit register width (derived; do not override).
- CNT_W, 16, width of the vend counter.

Ports:
- clk_i, input, 1, clock; all state updates on the rising edge.
- rst_i, input, 1, asynchronous active-high reset.
- coin_valid_i, input, 1, coin present this cycle.
- coin_i, input, 3, one-hot coin code: [0] nickel = 1 unit, [1] dime = 2 units, [2] quarter = 5 units.
- cancel_i, input, 1, request refund of all credit.
- soda_o, output, 1, one-cycle dispense pulse.
- coin_reject_o, output, 1, one-cycle pulse: the coin was not credited and the acceptor must return it.
- chg_valid_o, output, 1, change coin offered.
- chg_coin_o, output, 2, coin offered: 01 nickel, 10 dime, 11 quarter; 00 when chg_valid_o=0.
- chg_ready_i, input, 1, hopper accepts the offered coin.
- credit_o, output, CREDIT_W, current credit in units.
- busy_o, output, 1, high when the state is not IDLE.
- vend_count_o, output, CNT_W, total vends; wraps modulo 2^CNT_W.

Behaviour:
- All outputs are registered.
- Reset (async, any state, including mid-change): state=IDLE, credit=0, vend count=0, all outputs 0. Any coin being offered is dropped and chg_valid_o deasserts immediately.
- States: IDLE, VEND, CHANGE.
- IDLE, valid coin:
  - A coin is valid when coin_valid_i=1, coin_i is exactly one-hot, and credit+value <= MAX_CREDIT_U.
  - Let sum = credit+value.
  - If sum >= PRICE_U: next cycle state=VEND, soda_o=1, credit=sum-PRICE_U, vend count +1.
  - Otherwise: credit=sum and state stays IDLE.
- IDLE, invalid coin:
  - An invalid coin is coin_valid_i=1 with coin_i zero or multi-hot, or a coin that would overflow the credit.
  - Response: coin_reject_o=1 next cycle; credit unchanged.
- IDLE, cancel:
  - cancel_i=1 with credit>0: next state=CHANGE (refund); no soda.
  - cancel_i=1 with credit=0: ignored.
- IDLE, cancel and coin together: cancel wins. Any coin_valid_i coin is rejected with coin_reject_o=1.
- VEND:
  - Lasts exactly one cycle; soda_o is high only in this cycle.
  - Next state = CHANGE if credit>0, else IDLE.
- CHANGE:
  - Offer the greedy largest coin: quarter if credit>=5, else dime if credit>=2, else nickel.
  - chg_valid_o=1 and chg_coin_o stay stable until chg_ready_i=1.
  - On the handshake cycle, credit -= value. Next cycle either offers the next coin or, if credit reaches 0, returns to IDLE with chg_valid_o=0.
  - At most one coin per cycle; back-to-back handshakes are allowed.
- Coin or cancel while not IDLE:
  - coin_valid_i=1 gives coin_reject_o=1 next cycle and is not credited.
  - cancel_i is ignored.
- Latency:
  - Coin to soda_o: 1 cycle.
  - soda_o to first chg_valid_o: 1 cycle.
- Invariants:
  - credit_o <= MAX_CREDIT_U.
  - credit_o < PRICE_U whenever state=IDLE.
  - chg_valid_o implies state=CHANGE.
- vend_count_o: increments on entry to VEND; wraps from 2^CNT_W-1 to 0.

Test Plan:
- Defaults, quarter from 0 credit -> next cycle soda_o=1 and credit_o=1; then nickel offered (chg_coin_o=01), chg_ready_i=1 -> credit 0, IDLE, vend_count_o=1.
- Dime, dime (ready held 1) -> soda_o on the cycle after the second dime, no chg_valid_o, credit 0.
- Nickel, dime, quarter (credit 3+5=8 -> 4 left), chg_ready_i held 0 for 5 cycles -> chg_valid_o=1 with chg_coin_o=10 stable; then two dimes drain the credit.
- Nickel, dime, then cancel together with a coin -> coin_reject_o=1; refund dime then nickel; no soda_o.
- Illegal coin_i=011, and a coin inserted during CHANGE -> coin_reject_o=1 each time, credit unchanged.
- Reset asserted mid-CHANGE (chg_valid_o=1) -> all outputs 0 asynchronously; after release, nickel -> credit_o=1.

Source files
------------

// File: rtl/vend_ctrl.sv
// -----------------------------------------------------------------------------
// vend_ctrl
//   Soda vending controller with a programmable price. Credit is held in
//   5-cent units. When credit reaches the price, a one-cycle dispense pulse
//   is issued. Change, or a full refund on cancel, is paid out one coin at a
//   time over a valid/ready handshake to the coin-hopper driver.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   coin_valid_i   coin present this cycle
//   coin_i[2:0]    one-hot coin: [0] nickel=1, [1] dime=2, [2] quarter=5 units
//   cancel_i       refund all credit
//   soda_o         one-cycle dispense pulse
//   coin_reject_o  one-cycle pulse: coin not credited, acceptor returns it
//   chg_valid_o    change coin offered
//   chg_coin_o     offered coin: 01 nickel, 10 dime, 11 quarter, 00 when idle
//   chg_ready_i    hopper takes the offered coin
//   credit_o       current credit in units
//   busy_o         controller not in IDLE
//   vend_count_o   total vends, wraps modulo 2^CNT_W
//
// Every output comes straight from a flop. The output process computes the
// values for the next cycle, and the output register captures them.
// -----------------------------------------------------------------------------
module vend_ctrl #(
  parameter int PRICE_U      = 4,
  parameter int MAX_CREDIT_U = 15,
  parameter int CREDIT_W     = $clog2(MAX_CREDIT_U + 1),
  parameter int CNT_W        = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                coin_valid_i,
  input  logic [2:0]          coin_i,
  input  logic                cancel_i,
  output logic                soda_o,
  output logic                coin_reject_o,
  output logic                chg_valid_o,
  output logic [1:0]          chg_coin_o,
  input  logic                chg_ready_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    vend_count_o
);

  // The sum needs headroom above the credit width so that an overflowing
  // coin can be detected rather than silently wrapping.
  localparam int SUM_W = CREDIT_W + 3;
  localparam logic [SUM_W-1:0] PRICE_S = SUM_W'(PRICE_U);
  localparam logic [SUM_W-1:0] MAX_S   = SUM_W'(MAX_CREDIT_U);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n;
  logic [CNT_W-1:0]    vend_count;

  logic                soda_n, reject_n, chg_valid_n, busy_n;
  logic [1:0]          chg_coin_n;

  logic [2:0]          coin_value;
  logic                coin_onehot;
  logic [SUM_W-1:0]    sum;
  logic                coin_ok;
  logic                coin_accept;

  // Greedy change selection: the largest coin not exceeding the credit.
  function automatic logic [1:0] greedy_code(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(5))      return 2'b11;
    else if (c >= CREDIT_W'(2)) return 2'b10;
    else                        return 2'b01;
  endfunction

  function automatic logic [CREDIT_W-1:0] code_value(input logic [1:0] code);
    case (code)
      2'b11:   return CREDIT_W'(5);
      2'b10:   return CREDIT_W'(2);
      default: return CREDIT_W'(1);
    endcase
  endfunction

  // Coin decode. Zero or multi-hot codes are not coins at all.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    coin_value  = 3'd0;
    coin_onehot = 1'b1;
    case (coin_i)
      3'b001:  coin_value = 3'd1;
      3'b010:  coin_value = 3'd2;
      3'b100:  coin_value = 3'd5;
      default: coin_onehot = 1'b0;
    endcase
  end

  assign sum     = SUM_W'(credit) + SUM_W'(coin_value);
  assign coin_ok = coin_valid_i && coin_onehot && (sum <= MAX_S);

  // Next-state and next-credit logic.
  always_comb begin
    state_n     = state;
    credit_n    = credit;
    coin_accept = 1'b0;
    unique case (state)
      IDLE: begin
        // Cancel has priority. A coin arriving with it is rejected below.
        if (cancel_i) begin
          if (credit != '0) state_n = CHANGE;
        end else if (coin_ok) begin
          coin_accept = 1'b1;
          if (sum >= PRICE_S) begin
            state_n  = VEND;
            credit_n = CREDIT_W'(sum - PRICE_S);
          end else begin
            credit_n = CREDIT_W'(sum);
          end
        end
      end
      VEND: begin
        state_n = (credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        // The offered coin is always greedy_code(credit), because credit only
        // changes on a handshake.
        if (chg_ready_i) begin
          credit_n = credit - code_value(greedy_code(credit));
          if (credit_n == '0) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output values for the next cycle.
  always_comb begin
    soda_n      = (state == IDLE) && (state_n == VEND);
    reject_n    = coin_valid_i && !coin_accept;
    chg_valid_n = (state_n == CHANGE);
    chg_coin_n  = chg_valid_n ? greedy_code(credit_n) : 2'b00;
    busy_n      = (state_n != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      credit     <= '0;
      vend_count <= '0;
    end else begin
      state  <= state_n;
      credit <= credit_n;
      if (soda_n) vend_count <= vend_count + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      soda_o        <= 1'b0;
      coin_reject_o <= 1'b0;
      chg_valid_o   <= 1'b0;
      chg_coin_o    <= 2'b00;
      busy_o        <= 1'b0;
    end else begin
      soda_o        <= soda_n;
      coin_reject_o <= reject_n;
      chg_valid_o   <= chg_valid_n;
      chg_coin_o    <= chg_coin_n;
      busy_o        <= busy_n;
    end
  end

  assign credit_o     = credit;
  assign vend_count_o = vend_count;

endmodule

// File: tb/tb_vend_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_ctrl
//   Table-driven bench for vend_ctrl with default parameters. Each row holds
//   the inputs for one clock and the outputs expected after that edge. The
//   expectation is queued when the inputs are driven, then popped and
//   compared just after the edge. A second instance with a 2-bit vend counter
//   runs on the same stimulus to exercise counter wrap. A hand-written
//   sequence covers reset arriving asynchronously in the middle of a change
//   payout.
// -----------------------------------------------------------------------------
module tb_vend_ctrl;

  localparam logic [2:0] NI = 3'b001;
  localparam logic [2:0] DI = 3'b010;
  localparam logic [2:0] QU = 3'b100;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        coin_valid_i;
  logic [2:0]  coin_i;
  logic        cancel_i;
  logic        chg_ready_i;

  logic        soda_o, coin_reject_o, chg_valid_o, busy_o;
  logic [1:0]  chg_coin_o;
  logic [3:0]  credit_o;
  logic [15:0] vend_count_o;

  logic        soda_w, reject_w, chg_valid_w, busy_w;
  logic [1:0]  chg_coin_w;
  logic [3:0]  credit_w;
  logic [1:0]  vend_count_w;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        cvi;
    logic [2:0]  coin;
    logic        can;
    logic        rdy;
    logic        soda;
    logic        rej;
    logic        cv;
    logic [1:0]  cc;
    logic [3:0]  credit;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  vend_ctrl u_dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .coin_valid_i  (coin_valid_i),
    .coin_i        (coin_i),
    .cancel_i      (cancel_i),
    .soda_o        (soda_o),
    .coin_reject_o (coin_reject_o),
    .chg_valid_o   (chg_valid_o),
    .chg_coin_o    (chg_coin_o),
    .chg_ready_i   (chg_ready_i),
    .credit_o      (credit_o),
    .busy_o        (busy_o),
    .vend_count_o  (vend_count_o)
  );

  vend_ctrl #(.CNT_W(2)) u_dut_w (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .coin_valid_i  (coin_valid_i),
    .coin_i        (coin_i),
    .cancel_i      (cancel_i),
    .soda_o        (soda_w),
    .coin_reject_o (reject_w),
    .chg_valid_o   (chg_valid_w),
    .chg_coin_o    (chg_coin_w),
    .chg_ready_i   (chg_ready_i),
    .credit_o      (credit_w),
    .busy_o        (busy_w),
    .vend_count_o  (vend_count_w)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(input logic cvi, input logic [2:0] coin, input logic can,
                             input logic rdy, input logic soda, input logic rej,
                             input logic cv, input logic [1:0] cc, input int cr,
                             input logic busy, input int cnt);
    vec_t t;
    t.cvi = cvi; t.coin = coin; t.can = can; t.rdy = rdy;
    t.soda = soda; t.rej = rej; t.cv = cv; t.cc = cc;
    t.credit = 4'(cr); t.busy = busy; t.cnt = 16'(cnt);
    return t;
  endfunction

  task automatic compare(input int idx, input vec_t e);
    logic [1:0] cnt_w_exp;
    cnt_w_exp = e.cnt[1:0];
    check($sformatf("row%0d soda", idx),      32'(soda_o),        32'(e.soda));
    check($sformatf("row%0d reject", idx),    32'(coin_reject_o), 32'(e.rej));
    check($sformatf("row%0d chg_valid", idx), 32'(chg_valid_o),   32'(e.cv));
    check($sformatf("row%0d chg_coin", idx),  32'(chg_coin_o),    32'(e.cc));
    check($sformatf("row%0d credit", idx),    32'(credit_o),      32'(e.credit));
    check($sformatf("row%0d busy", idx),      32'(busy_o),        32'(e.busy));
    check($sformatf("row%0d vend_count", idx), 32'(vend_count_o), 32'(e.cnt));
    check($sformatf("row%0d vend_count_w", idx), 32'(vend_count_w), 32'(cnt_w_exp));
    check($sformatf("row%0d credit_w", idx),  32'(credit_w),      32'(e.credit));
  endtask

  task automatic step(input int idx, input vec_t t);
    coin_valid_i = t.cvi;
    coin_i       = t.coin;
    cancel_i     = t.can;
    chg_ready_i  = t.rdy;
    sb.push_back(t);
    @(posedge clk_i);
    #1;
    if (sb.size() == 0) begin
      check($sformatf("row%0d scoreboard underflow", idx), 32'd1, 32'd0);
    end else begin
      compare(idx, sb.pop_front());
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " soda"},         32'(soda_o),        32'd0);
    check({tag, " reject"},       32'(coin_reject_o), 32'd0);
    check({tag, " chg_valid"},    32'(chg_valid_o),   32'd0);
    check({tag, " chg_coin"},     32'(chg_coin_o),    32'd0);
    check({tag, " credit"},       32'(credit_o),      32'd0);
    check({tag, " busy"},         32'(busy_o),        32'd0);
    check({tag, " vend_count"},   32'(vend_count_o),  32'd0);
    check({tag, " vend_count_w"}, 32'(vend_count_w),  32'd0);
  endtask

  initial begin
    // Columns: coin_valid, coin, cancel, ready |
    //          soda, reject, chg_valid, chg_coin, credit, busy, vend_count
    // Quarter from zero credit: vend, one nickel of change.
    vecs.push_back(v(1, QU,   0, 0,  1, 0, 0, 2'b00, 1, 1, 1));
    vecs.push_back(v(0, 3'd0, 0, 0,  0, 0, 1, 2'b01, 1, 1, 1));
    vecs.push_back(v(0, 3'd0, 0, 1,  0, 0, 0, 2'b00, 0, 0, 1));
    // Dime, dime with ready held high: exact price, no change.
    vecs.push_back(v(1, DI,   0, 1,  0, 0, 0, 2'b00, 2, 0, 1));
    vecs.push_back(v(1, DI,   0, 1,  1, 0, 0, 2'b00, 0, 1, 2));
    vecs.push_back(v(0, 3'd0, 0, 1,  0, 0, 0, 2'b00, 0, 0, 2));
    // Nickel, dime, quarter: 4 units of change, hopper stalls 5 cycles.
    vecs.push_back(v(1, NI,   0, 0,  0, 0, 0, 2'b00, 1, 0, 2));
    vecs.push_back(v(1, DI,   0, 0,  0, 0, 0, 2'b00, 3, 0, 2));
    vecs.push_back(v(1, QU,   0, 0,  1, 0, 0, 2'b00, 4, 1, 3));
    for (int i = 0; i < 5; i++)
      vecs.push_back(v(0, 3'd0, 0, 0,  0, 0, 1, 2'b10, 4, 1, 3));
    vecs.push_back(v(0, 3'd0, 0, 1,  0, 0, 1, 2'b10, 2, 1, 3));
    vecs.push_back(v(0, 3'd0, 0, 1,  0, 0, 0, 2'b00, 0, 0, 3));
    // Nickel, dime, then cancel with a coin: reject, refund dime + nickel.
    vecs.push_back(v(1, NI,   0, 0,  0, 0, 0, 2'b00, 1, 0, 3));
    vecs.push_back(v(1, DI,   0, 0,  0, 0, 0, 2'b00, 3, 0, 3));
    vecs.push_back(v(1, NI,   1, 0,  0, 1, 1, 2'b10, 3, 1, 3));
    vecs.push_back(v(0, 3'd0, 0, 1,  0, 0, 1, 2'b01, 1, 1, 3));
    vecs.push_back(v(0, 3'd0, 0, 1,  0, 0, 0, 2'b00, 0, 0, 3));
    // Illegal multi-hot coin; then coin and cancel during CHANGE.
    vecs.push_back(v(1, NI,     0, 0,  0, 0, 0, 2'b00, 1, 0, 3));
    vecs.push_back(v(1, 3'b011, 0, 0,  0, 1, 0, 2'b00, 1, 0, 3));
    vecs.push_back(v(1, DI,     0, 0,  0, 0, 0, 2'b00, 3, 0, 3));
    vecs.push_back(v(0, 3'd0,   1, 0,  0, 0, 1, 2'b10, 3, 1, 3));
    vecs.push_back(v(1, QU,     1, 0,  0, 1, 1, 2'b10, 3, 1, 3));
    vecs.push_back(v(0, 3'd0,   0, 1,  0, 0, 1, 2'b01, 1, 1, 3));
    vecs.push_back(v(0, 3'd0,   0, 1,  0, 0, 0, 2'b00, 0, 0, 3));
    // Zero coin code rejected; cancel with zero credit ignored.
    vecs.push_back(v(1, 3'b000, 0, 0,  0, 1, 0, 2'b00, 0, 0, 3));
    vecs.push_back(v(0, 3'd0,   1, 0,  0, 0, 0, 2'b00, 0, 0, 3));
    // Exact price from nickels; coin during VEND rejected; 2-bit counter wraps.
    vecs.push_back(v(1, DI,   0, 0,  0, 0, 0, 2'b00, 2, 0, 3));
    vecs.push_back(v(1, NI,   0, 0,  0, 0, 0, 2'b00, 3, 0, 3));
    vecs.push_back(v(1, NI,   0, 0,  1, 0, 0, 2'b00, 0, 1, 4));
    vecs.push_back(v(1, NI,   0, 0,  0, 1, 0, 2'b00, 0, 0, 4));
    // Enter CHANGE by refund, ready held low, for the reset test below.
    vecs.push_back(v(1, NI,   0, 0,  0, 0, 0, 2'b00, 1, 0, 4));
    vecs.push_back(v(0, 3'd0, 1, 0,  0, 0, 1, 2'b01, 1, 1, 4));

    rst_i        = 1'b1;
    coin_valid_i = 1'b0;
    coin_i       = 3'd0;
    cancel_i     = 1'b0;
    chg_ready_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    foreach (vecs[i]) step(i, vecs[i]);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    // Mid-CHANGE reset: outputs must clear before the next clock edge.
    check("pre-reset chg_valid", 32'(chg_valid_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check_all_zero("async reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    step(100, v(1, NI, 0, 0,  0, 0, 0, 2'b00, 1, 0, 0));
    step(101, v(0, 3'd0, 0, 0,  0, 0, 0, 2'b00, 1, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
